// File: rtl/uart_boot_loader_ctrl_pkg.sv
// Shared types and constants for the UART boot loader: FSM states, error codes, protocol bytes.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_RESP,
        ST_DONE
    } boot_state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_LEN     = 3'd1,
        ERR_CSUM    = 3'd2,
        ERR_OVERRUN = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_code_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/uart_boot_loader_ctrl_if.sv
// UART byte stream and memory write port of the boot loader, bundled with controller/peer modports.
interface uart_boot_loader_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_ready,
        output tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_ready,
        input  tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/uart_boot_loader_ctrl_assembler.sv
// boot_word_assembler: packs data bytes into little-endian words and keeps the running 8-bit checksum.
module boot_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_vld_o,
    output logic [7:0]  sum_o
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;
    logic [7:0]  sum_q;

    // The 4th byte is combined combinationally so the word is usable in the same cycle it completes.
    assign word_o     = {byte_i, shift_q};
    assign word_vld_o = byte_vld_i && (cnt_q == 2'd3);
    assign sum_o      = sum_q;

    always_ff @(posedge clock) begin
        if (!reset || clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else if (byte_vld_i) begin
            shift_q <= {byte_i, shift_q[23:8]};
            cnt_q   <= cnt_q + 2'd1;
            sum_q   <= sum_q + byte_i;
        end
    end

endmodule

// File: rtl/uart_boot_loader_ctrl.sv
// UART boot loader: receives a framed image, writes it to RAM, then releases the CPU from reset.
// Optional inter-byte timeout is enabled by defining BOOT_LOADER_TIMEOUT_EN.
module uart_boot_loader_ctrl
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] LOAD_BASE      = 32'h0001_0100,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 200000
) (
    input  logic                    clock,
    input  logic                    reset,
    uart_boot_loader_ctrl_if.master bus,
    output logic                    cpu_hold,
    output logic                    boot_done,
    output logic [31:0]             start_pc,
    output logic [2:0]              err_code
);

    localparam int          IDX_W = $clog2(MAX_WORDS + 1);
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    boot_state_e      state_q;
    logic [7:0]       len_lo_q;
    logic [15:0]      len_q;
    logic [IDX_W-1:0] idx_q;
    logic             csum_ok_q;
    logic             mem_valid_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic             tx_valid_q;
    logic [7:0]       tx_data_q;
    logic             cpu_hold_q;
    logic             boot_done_q;
    err_code_e        err_q;

    logic [15:0]      len_d;
    logic [IDX_W-1:0] idx_d;
    err_code_e        fail_d;
    logic             sync_hit;
    logic             mem_busy;
    logic             tmo_hit;
    logic [31:0]      word;
    logic             word_vld;
    logic [7:0]       sum;

    assign sync_hit = (state_q == ST_IDLE) && bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    assign mem_busy = mem_valid_q && !bus.mem_ready;
    assign len_d    = {bus.rx_data, len_lo_q};
    assign idx_d    = idx_q + IDX_W'(1);

    boot_word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (sync_hit),
        .byte_vld_i ((state_q == ST_DATA) && bus.rx_valid),
        .byte_i     (bus.rx_data),
        .word_o     (word),
        .word_vld_o (word_vld),
        .sum_o      (sum)
    );

`ifdef BOOT_LOADER_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;
    logic        in_frame;

    assign in_frame = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    assign tmo_hit  = in_frame && !bus.rx_valid && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset || !in_frame || bus.rx_valid) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
    end
`else
    // Timer compiled out; the parameter stays so both builds share one instantiation.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Every abort path ends in the same NAK response, so the cause is resolved here first.
    always_comb begin
        fail_d = ERR_NONE;
        if (tmo_hit) begin
            fail_d = ERR_TIMEOUT;
        end else if ((state_q == ST_LEN_HI) && bus.rx_valid && (len_d > MAX_N)) begin
            fail_d = ERR_LEN;
        end else if ((state_q == ST_DATA) && word_vld && mem_busy) begin
            fail_d = ERR_OVERRUN;
        end else if ((state_q == ST_CSUM) && !csum_ok_q && bus.rx_valid && (bus.rx_data != sum)) begin
            fail_d = ERR_CSUM;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            csum_ok_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            cpu_hold_q  <= 1'b1;
            boot_done_q <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            // A pending write always runs to completion, whatever the FSM does meanwhile.
            if (mem_valid_q && bus.mem_ready) begin
                mem_valid_q <= 1'b0;
            end

            if (fail_d != ERR_NONE) begin
                state_q    <= ST_RESP;
                tx_valid_q <= 1'b1;
                tx_data_q  <= NAK_BYTE;
                err_q      <= fail_d;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (sync_hit) begin
                            err_q     <= ERR_NONE;
                            csum_ok_q <= 1'b0;
                            state_q   <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (bus.rx_valid) begin
                            len_lo_q <= bus.rx_data;
                            state_q  <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (bus.rx_valid) begin
                            len_q   <= len_d;
                            idx_q   <= '0;
                            state_q <= (len_d == 16'd0) ? ST_CSUM : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (word_vld) begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= word_addr(LOAD_BASE, 32'(idx_q));
                            mem_wdata_q <= word;
                            idx_q       <= idx_d;
                            if (16'(idx_d) == len_q) begin
                                state_q <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        // A matching checksum still waits for the last write before acknowledging.
                        if (csum_ok_q || bus.rx_valid) begin
                            if (!mem_busy) begin
                                state_q    <= ST_RESP;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= ACK_BYTE;
                            end else begin
                                csum_ok_q <= 1'b1;
                            end
                        end
                    end
                    ST_RESP: begin
                        if (bus.tx_ready) begin
                            tx_valid_q <= 1'b0;
                            if (tx_data_q == ACK_BYTE) begin
                                state_q     <= ST_DONE;
                                boot_done_q <= 1'b1;
                                cpu_hold_q  <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_valid_q ? 4'hF : 4'h0;
    assign cpu_hold      = cpu_hold_q;
    assign boot_done     = boot_done_q;
    assign start_pc      = LOAD_BASE;
    assign err_code      = err_q;

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Bench for uart_boot_loader_ctrl: frame table, random frames against a reference model, handshake corner cases.
module tb_uart_boot_loader_ctrl;
    import boot_loader_pkg::*;

    localparam logic [31:0] LOAD_BASE = 32'h0001_0100;
    localparam int          MAX_WORDS = 1024;

    typedef struct {
        logic [15:0] n;
        logic [7:0]  delta;
        bit          stray;
        bit          fixed;
        int          gapmax;
        logic [7:0]  exp_resp;
        logic [2:0]  exp_err;
        bit          exp_done;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_hold;
    logic        boot_done;
    logic [31:0] start_pc;
    logic [2:0]  err_code;

    int checks   = 0;
    int failures = 0;
    int bus_bad  = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  resp_q[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    vec_t        vecs[9];

    always #5 clock = ~clock;

    uart_boot_loader_ctrl_if bus();

    uart_boot_loader_ctrl #(
        .LOAD_BASE      (LOAD_BASE),
        .MAX_WORDS      (MAX_WORDS),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .boot_done (boot_done),
        .start_pc  (start_pc),
        .err_code  (err_code)
    );

    always @(posedge clock) begin
        if (bus.mem_valid && bus.mem_ready) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
        if (bus.tx_valid && bus.tx_ready) resp_q.push_back(bus.tx_data);
        if (bus.mem_wstrb !== (bus.mem_valid ? 4'hF : 4'h0)) bus_bad++;
        if (bus.mem_valid && bus.mem_addr[1:0] != 2'b00) bus_bad++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        resp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        bus.tx_ready  = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        clear_mon();
    endtask

    // Called at a negedge; returns at a negedge after the byte strobe and the idle gap.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clock);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic wait_resp(input int budget, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (resp_q.size() > 0) got = 1'b1;
        end
    endtask

    // Reference model: builds the frame, predicts the RAM image and the response from the frame rules.
    task automatic send_frame(input logic [15:0] n, input logic [7:0] delta, input bit stray,
                              input bit fixed, input int gapmax,
                              output logic [7:0] m_resp, output logic [2:0] m_err);
        logic [7:0]  sum;
        logic [31:0] w;
        exp_wa.delete();
        exp_wd.delete();
        if (stray) begin
            send_byte(8'h11, 1);
            send_byte(8'h22, 1);
        end
        send_byte(SYNC_BYTE, 1);
        send_byte(n[7:0], 1);
        send_byte(n[15:8], 1);
        if (int'(n) > MAX_WORDS) begin
            m_resp = NAK_BYTE;
            m_err  = 3'd1;
            return;
        end
        sum = 8'd0;
        for (int i = 0; i < int'(n); i++) begin
            w = fixed ? 32'(i + 1) : $urandom;
            exp_wa.push_back(LOAD_BASE + 32'(i) * 32'd4);
            exp_wd.push_back(w);
            for (int b = 0; b < 4; b++) begin
                sum = sum + w[8*b +: 8];
                send_byte(w[8*b +: 8], int'($urandom_range(0, gapmax)));
            end
        end
        send_byte(sum + delta, 0);
        m_resp = (delta == 8'd0) ? ACK_BYTE : NAK_BYTE;
        m_err  = (delta == 8'd0) ? 3'd0 : 3'd2;
    endtask

    task automatic check_frame(input string name, input logic [7:0] exp_resp,
                               input logic [2:0] exp_err, input bit exp_done);
        bit got;
        int cyc;
        int bad;
        wait_resp(600, got, cyc);
        check({name, " resp_seen"}, 32'(got), 32'd1);
        if (got) check({name, " resp"}, 32'(resp_q[0]), 32'(exp_resp));
        repeat (2) @(negedge clock);
        check({name, " nresp"}, resp_q.size(), 32'd1);
        check({name, " err"}, 32'(err_code), 32'(exp_err));
        check({name, " done"}, 32'(boot_done), 32'(exp_done));
        check({name, " hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({name, " nwr"}, wr_addr_q.size(), exp_wa.size());
        bad = 0;
        if (wr_addr_q.size() == exp_wa.size()) begin
            foreach (exp_wa[i]) begin
                if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) bad++;
            end
        end
        check({name, " wimage"}, bad, 32'd0);
    endtask

    initial begin
        logic [7:0]  mr;
        logic [2:0]  me;
        logic [15:0] n;
        logic [7:0]  d;
        bit          got;
        int          cyc;

        bus.rx_data   = 8'd0;
        bus.rx_valid  = 1'b0;
        bus.tx_ready  = 1'b1;
        bus.mem_ready = 1'b1;

        vecs[0] = '{16'd2,    8'h00, 1'b0, 1'b1, 1, ACK_BYTE, 3'd0, 1'b1};
        vecs[1] = '{16'd2,    8'h01, 1'b0, 1'b1, 1, NAK_BYTE, 3'd2, 1'b0};
        vecs[2] = '{16'd1025, 8'h00, 1'b0, 1'b0, 1, NAK_BYTE, 3'd1, 1'b0};
        vecs[3] = '{16'd0,    8'h00, 1'b1, 1'b0, 1, ACK_BYTE, 3'd0, 1'b1};
        vecs[4] = '{16'd5,    8'h00, 1'b0, 1'b0, 2, ACK_BYTE, 3'd0, 1'b1};
        vecs[5] = '{16'd3,    8'h80, 1'b0, 1'b0, 1, NAK_BYTE, 3'd2, 1'b0};
        vecs[6] = '{16'd1024, 8'h00, 1'b0, 1'b0, 0, ACK_BYTE, 3'd0, 1'b1};
        vecs[7] = '{16'd0,    8'h01, 1'b0, 1'b0, 1, NAK_BYTE, 3'd2, 1'b0};
        vecs[8] = '{16'd1,    8'h00, 1'b1, 1'b0, 3, ACK_BYTE, 3'd0, 1'b1};

        // Reset values, sampled while reset is held low.
        @(negedge clock);
        repeat (2) @(negedge clock);
        check("rst tx_valid",  32'(bus.tx_valid),  32'd0);
        check("rst tx_data",   32'(bus.tx_data),   32'd0);
        check("rst mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst mem_addr",  bus.mem_addr,       32'd0);
        check("rst mem_wdata", bus.mem_wdata,      32'd0);
        check("rst mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst cpu_hold",  32'(cpu_hold),      32'd1);
        check("rst boot_done", 32'(boot_done),     32'd0);
        check("rst err_code",  32'(err_code),      32'd0);
        check("start_pc",      start_pc,           32'h0001_0100);
        reset = 1'b1;

        for (int v = 0; v < 9; v++) begin
            do_reset();
            send_frame(vecs[v].n, vecs[v].delta, vecs[v].stray, vecs[v].fixed, vecs[v].gapmax, mr, me);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_resp, vecs[v].exp_err, vecs[v].exp_done);
        end

        // The known-answer frame lands at the documented addresses.
        do_reset();
        send_frame(16'd2, 8'h00, 1'b0, 1'b1, 0, mr, me);
        repeat (4) @(negedge clock);
        check("ka nwr", wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check("ka addr0", wr_addr_q[0], 32'h0001_0100);
            check("ka data0", wr_data_q[0], 32'h0000_0001);
            check("ka addr1", wr_addr_q[1], 32'h0001_0104);
            check("ka data1", wr_data_q[1], 32'h0000_0002);
        end

        for (int r = 0; r < 12; r++) begin
            do_reset();
            n = ($urandom_range(0, 7) == 0) ? 16'(1025 + $urandom_range(0, 60000))
                                            : 16'($urandom_range(0, 6));
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            send_frame(n, d, 1'($urandom_range(0, 1)), 1'b0, 3, mr, me);
            check_frame($sformatf("rnd%0d", r), mr, me, mr == ACK_BYTE);
        end

        // A NAKed frame leaves the loader ready for a fresh one without reset.
        do_reset();
        send_frame(16'd1, 8'h05, 1'b0, 1'b0, 1, mr, me);
        check_frame("retry nak", NAK_BYTE, 3'd2, 1'b0);
        clear_mon();
        send_frame(16'd2, 8'h00, 1'b0, 1'b1, 1, mr, me);
        check_frame("retry ack", ACK_BYTE, 3'd0, 1'b1);

        // Overrun: second word completes while the first write is still stalled.
        do_reset();
        bus.mem_ready = 1'b0;
        exp_wa.delete();
        exp_wd.delete();
        send_byte(SYNC_BYTE, 1);
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        for (int b = 0; b < 4; b++) send_byte(8'hEF - 8'(b * 17), 1);
        for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b), 1);
        wait_resp(50, got, cyc);
        check("ovr resp_seen", 32'(got), 32'd1);
        if (got) check("ovr resp", 32'(resp_q[0]), 32'(NAK_BYTE));
        check("ovr err", 32'(err_code), 32'd3);
        check("ovr pending", 32'(bus.mem_valid), 32'd1);
        check("ovr nwr0", wr_addr_q.size(), 32'd0);
        bus.mem_ready = 1'b1;
        repeat (6) @(negedge clock);
        check("ovr nwr1", wr_addr_q.size(), 32'd1);
        if (wr_addr_q.size() > 0) begin
            check("ovr addr", wr_addr_q[0], 32'h0001_0100);
            check("ovr data", wr_data_q[0], 32'hBCCDDEEF);
        end
        check("ovr drop", 32'(bus.mem_valid), 32'd0);
        check("ovr hold", 32'(cpu_hold), 32'd1);

        // Matching checksum waits for the outstanding write; ACK timing against tx_ready.
        do_reset();
        bus.mem_ready = 1'b0;
        bus.tx_ready  = 1'b0;
        send_frame(16'd1, 8'h00, 1'b0, 1'b0, 1, mr, me);
        repeat (5) @(negedge clock);
        check("cwait no_tx", 32'(bus.tx_valid), 32'd0);
        bus.mem_ready = 1'b1;
        repeat (4) @(negedge clock);
        check("cwait tx_valid", 32'(bus.tx_valid), 32'd1);
        check("cwait tx_data", 32'(bus.tx_data), 32'(ACK_BYTE));
        check("cwait hold_pre", 32'(cpu_hold), 32'd1);
        check("cwait nwr", wr_addr_q.size(), 32'd1);
        bus.tx_ready = 1'b1;
        @(negedge clock);
        check("cwait done", 32'(boot_done), 32'd1);
        check("cwait hold", 32'(cpu_hold), 32'd0);
        check("cwait tx_drop", 32'(bus.tx_valid), 32'd0);

        // DONE ignores any further traffic.
        send_byte(SYNC_BYTE, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        for (int b = 0; b < 5; b++) send_byte(8'h33, 1);
        repeat (4) @(negedge clock);
        check("done nresp", resp_q.size(), 32'd1);
        check("done nwr", wr_addr_q.size(), 32'd1);
        check("done sticky", 32'(boot_done), 32'd1);

        // Stall after the length bytes.
        do_reset();
        send_byte(SYNC_BYTE, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        wait_resp(300, got, cyc);
`ifdef BOOT_LOADER_TIMEOUT_EN
        check("tmo resp_seen", 32'(got), 32'd1);
        if (got) check("tmo resp", 32'(resp_q[0]), 32'(NAK_BYTE));
        check("tmo window", 32'(cyc >= 95 && cyc <= 110), 32'd1);
        check("tmo err", 32'(err_code), 32'd4);
`else
        check("stall no_resp", 32'(got), 32'd0);
        check("stall err", 32'(err_code), 32'd0);
`endif
        check("stall hold", 32'(cpu_hold), 32'd1);

        // Reset mid-write drops everything, including the pending request.
        do_reset();
        send_frame(16'd0, 8'h01, 1'b0, 1'b0, 1, mr, me);
        repeat (4) @(negedge clock);
        bus.mem_ready = 1'b0;
        send_byte(SYNC_BYTE, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        for (int b = 0; b < 4; b++) send_byte(8'h5A, 1);
        check("mid pre_valid", 32'(bus.mem_valid), 32'd1);
        check("mid pre_tx", 32'(bus.tx_data), 32'(NAK_BYTE));
        reset = 1'b0;
        @(negedge clock);
        check("mid tx_valid",  32'(bus.tx_valid),  32'd0);
        check("mid tx_data",   32'(bus.tx_data),   32'd0);
        check("mid mem_valid", 32'(bus.mem_valid), 32'd0);
        check("mid mem_addr",  bus.mem_addr,       32'd0);
        check("mid mem_wdata", bus.mem_wdata,      32'd0);
        check("mid cpu_hold",  32'(cpu_hold),      32'd1);
        check("mid boot_done", 32'(boot_done),     32'd0);
        check("mid err_code",  32'(err_code),      32'd0);
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        clear_mon();
        @(negedge clock);
        send_frame(16'd3, 8'h00, 1'b0, 1'b0, 1, mr, me);
        check_frame("post_rst", ACK_BYTE, 3'd0, 1'b1);

        check("bus protocol", bus_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader_ctrl.md
Name: uart_boot_loader_ctrl

Overview:
- Sequences a serial boot image from the UART RX byte stream into on-chip RAM through a PicoRV32-style memory master port.
- Holds the RISC-V core in reset until the image is loaded and verified, then releases it.
- Sits between the UART RX/TX byte interface and the RAM-side memory adapter.
- Replaces testbench-side force/release loading with a real hardware load path.

Parameters:
- LOAD_BASE, 32'h0001_0100, byte address of the first word written; also the reported start PC.
- MAX_WORDS, 1024, largest accepted word count N.
- TIMEOUT_CYCLES, 200000, maximum idle cycles between bytes inside a frame.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  response byte
- tx_valid  out  1  response byte valid; held until tx_ready
- tx_ready  in  1  UART TX accepts byte
- mem_valid  out  1  write request; held until mem_ready
- mem_addr  out  32  word-aligned write address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  always 4'hF while mem_valid, else 0
- mem_ready  in  1  write accepted this cycle
- cpu_hold  out  1  1 = keep CPU in reset
- boot_done  out  1  sticky, image accepted
- start_pc  out  32  constant LOAD_BASE
- err_code  out  3  last error: 0 none, 1 bad length, 2 checksum, 3 overrun, 4 timeout

Behaviour:
- Reset values: tx_valid=0, tx_data=0, mem_valid=0, mem_addr=0, mem_wdata=0, cpu_hold=1, boot_done=0, err_code=0; FSM enters IDLE. Reset mid-frame or mid-write drops everything, including any pending mem_valid.
- Frame format: 0xA5 sync, then N as 2 bytes little-endian, then N*4 data bytes, then 1 checksum byte.
  - Data bytes form little-endian words: first byte goes to bits [7:0].
  - Checksum = 8-bit sum (mod 256) of all data bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, RESP, DONE.
  - IDLE: on rx_valid && rx_data==8'hA5, go to LEN_LO. Any other byte is ignored.
  - LEN_LO: latch the low length byte, go to LEN_HI.
  - LEN_HI: latch the high byte. If N>MAX_WORDS, err=1 and go to RESP with NAK. If N==0, go to CSUM. Otherwise clear the word index and byte counter, go to DATA.
  - DATA: shift each byte in and add it to the running sum. On the 4th byte, present word i:
    - mem_valid=1 the next cycle, mem_addr=LOAD_BASE+4*i.
    - The write completes on the cycle mem_valid && mem_ready; mem_valid drops the following cycle.
    - If a new word completes while the previous write is still pending, err=3, go to RESP with NAK. The pending write is allowed to finish.
    - After the last word's byte, go to CSUM. The write may still be outstanding.
  - CSUM: the received byte is compared with the sum. On match, wait for any outstanding write to complete, then RESP with ACK 8'h06. On mismatch, err=2, RESP with NAK 8'h15.
  - RESP: assert tx_valid with the response byte until tx_ready.
    - ACK: go to DONE; boot_done=1 and cpu_hold=0 on the cycle after the handshake.
    - NAK: go to IDLE; cpu_hold stays 1.
  - DONE: terminal until reset. rx bytes are ignored.
- err_code is cleared to 0 on the next accepted sync byte.
- A new frame's sync is accepted only in IDLE. rx_valid during RESP is discarded.
- Word index counter wraps are impossible because N<=MAX_WORDS is checked first.

Optional Feature:
- Macro BOOT_LOADER_TIMEOUT_EN.
- Defined: a counter reloads on every rx_valid in LEN_LO..CSUM. If it reaches TIMEOUT_CYCLES, err=4 and go to RESP with NAK. IDLE and DONE never time out.
- Undefined: no counter; the FSM waits indefinitely and err_code never takes value 4.

Decomposition:
- Package boot_loader_pkg holds:
  - state enum boot_state_e
  - constants SYNC_BYTE=8'hA5, ACK_BYTE=8'h06, NAK_BYTE=8'h15
  - err_code enum
- Natural sub-module: boot_word_assembler.
  - Contains the byte shift register, 2-bit byte counter, running checksum and word_valid strobe.
  - The top FSM owns the memory and TX handshakes.

Test Plan:
- Frame A5 02 00, data 01 00 00 00 02 00 00 00, checksum 03, mem_ready=1 -> writes 32'h1 @0x10100 and 32'h2 @0x10104; ACK 0x06; cpu_hold falls; boot_done=1.
- Same frame with checksum 04 -> both writes still occur; NAK 0x15; err_code=2; cpu_hold=1. A following valid frame is then accepted.
- Length bytes 01 04 (N=1025) -> no memory writes; NAK; err_code=1.
- A5 00 00 00 -> no writes; ACK. Stray bytes 0x11 0x22 before the sync are ignored.
- mem_ready tied low while 8 data bytes arrive -> NAK with err_code=3. Then drive mem_ready=1: the first write completes exactly once.
- BOOT_LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, stall after the length bytes -> NAK at cycle 100; err_code=4. Asserting reset low mid-frame returns all outputs to their reset values.
